// File: rtl/seg7_pkg.sv
// Shared constants, FSM state type and anode-select helper for the 7-segment scan capture.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_e;

    typedef struct packed {
        logic       legal;
        logic [1:0] idx;
    } sel_t;

    // Exactly one active-low anode is a legal select; anything else is "no select".
    function automatic sel_t onehot0_low(input logic [3:0] an);
        sel_t s;
        s = '{legal: 1'b1, idx: 2'd0};
        case (an)
            4'b1110: s.idx = 2'd0;
            4'b1101: s.idx = 2'd1;
            4'b1011: s.idx = 2'd2;
            4'b0111: s.idx = 2'd3;
            default: s.legal = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_scan_capture_decode.sv
// Combinational active-low gfedcba pattern to BCD decoder.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       legal_o,
    output logic       blank_o,
    output logic [3:0] value_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        legal_o = 1'b1;
        blank_o = 1'b0;
        value_o = 4'd0;
        case (seg_i)
            SEG_0:     value_o = 4'd0;
            SEG_1:     value_o = 4'd1;
            SEG_2:     value_o = 4'd2;
            SEG_3:     value_o = 4'd3;
            SEG_4:     value_o = 4'd4;
            SEG_5:     value_o = 4'd5;
            SEG_6:     value_o = 4'd6;
            SEG_7:     value_o = 4'd7;
            SEG_8:     value_o = 4'd8;
            SEG_9:     value_o = 4'd9;
            SEG_BLANK: begin
                legal_o = 1'b0;
                blank_o = 1'b1;
            end
            default:   legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Samples a multiplexed common-anode display bus, filters each digit for stability and
// publishes a decoded per-digit register file with frame and stale indications.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned TIMEOUT    = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an_i,
    input  logic [6:0]  seg_i,
    output logic [15:0] digits_o,
    output logic [3:0]  dig_valid_o,
    output logic [3:0]  dig_blank_o,
    output logic [3:0]  dig_err_o,
    output logic        frame_valid_o,
    output logic        stale_o
);

    localparam logic [7:0]  STABLE_C = 8'(STABLE_CNT);
    localparam logic [23:0] TMO_C    = 24'(TIMEOUT);

    logic [3:0]  an_q;
    logic [6:0]  seg_q;
    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [6:0]  pat_q, pat_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [23:0] tmo_q, tmo_d;
    logic [3:0]  mask_q, mask_d, mask_set;
    logic [15:0] digits_q, digits_d;
    logic [3:0]  valid_q, valid_d, blank_q, blank_d, err_q, err_d;
    logic        frame_q, frame_d;

    sel_t        sel;
    logic        match, relatch, commit;
    logic        dec_legal, dec_blank;
    logic [3:0]  dec_value;

    assign sel   = onehot0_low(an_q);
    assign match = sel.legal && (sel.idx == idx_q) && (seg_q == pat_q);

    seg7_pattern_decode u_decode (
        .seg_i   (seg_q),
        .legal_o (dec_legal),
        .blank_o (dec_blank),
        .value_o (dec_value)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        relatch = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: relatch = sel.legal;
            SETTLE: begin
                if (!sel.legal) begin
                    state_d = IDLE;
                end else if (match) begin
                    // A count already at target only happens for STABLE_CNT=1, committed on relatch.
                    if (cnt_q >= STABLE_C) begin
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_d == STABLE_C) begin
                            commit  = 1'b1;
                            state_d = HOLD;
                        end
                    end
                end else begin
                    relatch = 1'b1;
                end
            end
            HOLD: begin
                if (!sel.legal) state_d = IDLE;
                else if (!match) relatch = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (relatch) begin
            idx_d   = sel.idx;
            pat_d   = seg_q;
            cnt_d   = 8'd1;
            state_d = SETTLE;
            commit  = (STABLE_C == 8'd1);
        end
    end

    always_comb begin
        digits_d = digits_q;
        valid_d  = valid_q;
        blank_d  = blank_q;
        err_d    = err_q;
        mask_d   = mask_q;
        frame_d  = 1'b0;
        mask_set = mask_q | (4'b0001 << sel.idx);
        tmo_d    = (tmo_q == TMO_C) ? tmo_q : tmo_q + 24'd1;
        if (commit) begin
            tmo_d = 24'd0;
            if (mask_set == 4'b1111) begin
                frame_d = 1'b1;
                mask_d  = 4'b0000;
            end else begin
                mask_d  = mask_set;
            end
            valid_d[sel.idx] = dec_legal;
            blank_d[sel.idx] = dec_blank;
            err_d[sel.idx]   = !dec_legal && !dec_blank;
            if (dec_legal) digits_d[{sel.idx, 2'b00} +: 4] = dec_value;
        end
    end

    // NOTE: the digit register file is only 16+12 flops, so it is reset like any other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q     <= 4'hF;
            seg_q    <= SEG_BLANK;
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            pat_q    <= SEG_BLANK;
            cnt_q    <= 8'd0;
            tmo_q    <= 24'd0;
            mask_q   <= 4'd0;
            digits_q <= 16'd0;
            valid_q  <= 4'd0;
            blank_q  <= 4'd0;
            err_q    <= 4'd0;
            frame_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            an_q     <= an_i;
            seg_q    <= seg_i;
            state_q  <= state_d;
            idx_q    <= idx_d;
            pat_q    <= pat_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            mask_q   <= mask_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            blank_q  <= blank_d;
            err_q    <= err_d;
            frame_q  <= frame_d;
        end
    end

    assign digits_o      = digits_q;
    assign dig_valid_o   = valid_q;
    assign dig_blank_o   = blank_q;
    assign dig_err_o     = err_q;
    assign frame_valid_o = frame_q;
    assign stale_o       = (tmo_q == TMO_C);

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed self-checking bench for seg7_scan_capture (STABLE_CNT=4, TIMEOUT=64, plus a STABLE_CNT=1 instance).
module tb_seg7_scan_capture;
    import seg7_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  an_i = 4'hF;
    logic [6:0]  seg_i = 7'h7F;
    logic [15:0] digits_o, digits1_o;
    logic [3:0]  dig_valid_o, dig_blank_o, dig_err_o;
    logic [3:0]  dig_valid1_o, dig_blank1_o, dig_err1_o;
    logic        frame_valid_o, stale_o, frame_valid1_o, stale1_o;

    int checks = 0;
    int failures = 0;
    int frame_cnt = 0;
    int saw3_cnt = 0;
    logic err3_at_pulse = 1'b0;
    logic blank2_at_pulse = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_capture #(.STABLE_CNT(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .an_i(an_i), .seg_i(seg_i),
        .digits_o(digits_o), .dig_valid_o(dig_valid_o), .dig_blank_o(dig_blank_o),
        .dig_err_o(dig_err_o), .frame_valid_o(frame_valid_o), .stale_o(stale_o)
    );

    seg7_scan_capture #(.STABLE_CNT(1), .TIMEOUT(64)) dut1 (
        .clk(clk), .rst(rst), .an_i(an_i), .seg_i(seg_i),
        .digits_o(digits1_o), .dig_valid_o(dig_valid1_o), .dig_blank_o(dig_blank1_o),
        .dig_err_o(dig_err1_o), .frame_valid_o(frame_valid1_o), .stale_o(stale1_o)
    );

    always @(negedge clk) begin
        if (frame_valid_o) begin
            frame_cnt       <= frame_cnt + 1;
            err3_at_pulse   <= dig_err_o[3];
            blank2_at_pulse <= dig_blank_o[2];
        end
        if (dig_valid_o[1] && digits_o[7:4] == 4'd3) saw3_cnt <= saw3_cnt + 1;
    end

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
        for (int i = 0; i < n; i++) begin
            an_i  = an;
            seg_i = seg;
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        drive(4'hF, SEG_BLANK, n);
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (digits_o !== 16'd0 || dig_valid_o !== 4'd0 || dig_blank_o !== 4'd0 ||
            dig_err_o !== 4'd0 || frame_valid_o !== 1'b0 || stale_o !== 1'b0) begin
            failures++;
            $display("FAIL %s: digits=%h valid=%b blank=%b err=%b frame=%b stale=%b, required all 0",
                     name, digits_o, dig_valid_o, dig_blank_o, dig_err_o, frame_valid_o, stale_o);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        an_i  = 4'hF;
        seg_i = SEG_BLANK;
        rst   = 1'b1;
        #1;
        check_all_zero("reset_state");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_settle();
        apply_reset();
        drive(4'b1110, SEG_2, 2);
        rst = 1'b1;
        #1;
        check_all_zero("reset_mid_settle");
        @(negedge clk);
        rst = 1'b0;
        drive(4'b1110, SEG_2, 4);
        checks++;
        if (dig_valid_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL early_commit: valid0=%b, required 0 before 4th sample commits", dig_valid_o[0]);
        end
        idle(1);
        checks++;
        if (digits_o[3:0] !== 4'd2 || dig_valid_o !== 4'b0001 || dig_err_o !== 4'd0) begin
            failures++;
            $display("FAIL reset_recommit: digit0=%h valid=%b err=%b, required 2 0001 0000",
                     digits_o[3:0], dig_valid_o, dig_err_o);
        end
    endtask

    task automatic test_glitch();
        int base;
        apply_reset();
        base = saw3_cnt;
        drive(4'b1101, SEG_3, 3);
        drive(4'b1101, SEG_4, 3);
        checks++;
        if (dig_valid_o[1] !== 1'b0) begin
            failures++;
            $display("FAIL glitch_early: valid1=%b, required 0", dig_valid_o[1]);
        end
        drive(4'b1101, SEG_4, 1);
        idle(1);
        checks++;
        if (digits_o[7:4] !== 4'd4 || dig_valid_o[1] !== 1'b1 || saw3_cnt != base) begin
            failures++;
            $display("FAIL glitch_commit: digit1=%h valid1=%b cycles_at_3=%0d, required 4 1 0",
                     digits_o[7:4], dig_valid_o[1], saw3_cnt - base);
        end
    endtask

    task automatic test_full_frame();
        int base;
        apply_reset();
        base = frame_cnt;
        drive(4'b1110, SEG_9, 6);
        drive(4'b1101, SEG_7, 6);
        drive(4'b1011, SEG_BLANK, 6);
        checks++;
        if (frame_cnt != base) begin
            failures++;
            $display("FAIL frame_early: pulses=%0d, required 0 before digit 3", frame_cnt - base);
        end
        drive(4'b0111, 7'b0101010, 6);
        idle(2);
        checks++;
        if (digits_o !== 16'h0079 || dig_valid_o !== 4'b0011 ||
            dig_blank_o !== 4'b0100 || dig_err_o !== 4'b1000) begin
            failures++;
            $display("FAIL frame_regs: digits=%h valid=%b blank=%b err=%b, required 0079 0011 0100 1000",
                     digits_o, dig_valid_o, dig_blank_o, dig_err_o);
        end
        checks++;
        if (frame_cnt != base + 1 || err3_at_pulse !== 1'b1 || blank2_at_pulse !== 1'b1) begin
            failures++;
            $display("FAIL frame_pulse: pulses=%0d err3_at_pulse=%b blank2_at_pulse=%b, required 1 1 1",
                     frame_cnt - base, err3_at_pulse, blank2_at_pulse);
        end
    endtask

    task automatic test_ghosting();
        apply_reset();
        drive(4'b1100, SEG_8, 10);
        checks++;
        if (dig_valid_o !== 4'd0 || dig_blank_o !== 4'd0 || dig_err_o !== 4'd0 || dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL ghost_multi: valid=%b blank=%b err=%b state=%0d, required no commit and IDLE",
                     dig_valid_o, dig_blank_o, dig_err_o, dut.state_q);
        end
        drive(4'b1111, SEG_8, 10);
        checks++;
        if (dig_valid_o !== 4'd0 || dig_blank_o !== 4'd0 || dig_err_o !== 4'd0 || dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL ghost_none: valid=%b blank=%b err=%b state=%0d, required no commit and IDLE",
                     dig_valid_o, dig_blank_o, dig_err_o, dut.state_q);
        end
    endtask

    task automatic test_repeat_digit();
        int base;
        apply_reset();
        base = frame_cnt;
        drive(4'b1110, SEG_1, 6);
        idle(3);
        drive(4'b1110, SEG_2, 6);
        drive(4'b1101, SEG_3, 6);
        drive(4'b1011, SEG_4, 6);
        checks++;
        if (frame_cnt != base) begin
            failures++;
            $display("FAIL repeat_early: pulses=%0d, required 0 before digit 3", frame_cnt - base);
        end
        drive(4'b0111, SEG_5, 6);
        idle(2);
        checks++;
        if (frame_cnt != base + 1 || digits_o !== 16'h5432 || dig_valid_o !== 4'b1111) begin
            failures++;
            $display("FAIL repeat_frame: pulses=%0d digits=%h valid=%b, required 1 5432 1111",
                     frame_cnt - base, digits_o, dig_valid_o);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        idle(63);
        checks++;
        if (stale_o !== 1'b0) begin
            failures++;
            $display("FAIL stale_early: stale=%b at cycle 63, required 0", stale_o);
        end
        idle(1);
        checks++;
        if (stale_o !== 1'b1) begin
            failures++;
            $display("FAIL stale_set: stale=%b at cycle 64, required 1", stale_o);
        end
        idle(10);
        drive(4'b1011, SEG_7, 4);
        checks++;
        if (stale_o !== 1'b1) begin
            failures++;
            $display("FAIL stale_hold: stale=%b before commit, required 1", stale_o);
        end
        idle(1);
        checks++;
        if (stale_o !== 1'b0 || digits_o[11:8] !== 4'd7 || dig_valid_o[2] !== 1'b1) begin
            failures++;
            $display("FAIL stale_clear: stale=%b digit2=%h valid2=%b, required 0 7 1",
                     stale_o, digits_o[11:8], dig_valid_o[2]);
        end
    endtask

    task automatic test_stable_one();
        apply_reset();
        drive(4'b1101, SEG_8, 1);
        checks++;
        if (dig_valid1_o[1] !== 1'b0) begin
            failures++;
            $display("FAIL s1_early: valid1=%b, required 0 before first sample is seen", dig_valid1_o[1]);
        end
        idle(1);
        checks++;
        if (digits1_o[7:4] !== 4'd8 || dig_valid1_o !== 4'b0010 || dut1.state_q !== SETTLE) begin
            failures++;
            $display("FAIL s1_commit: digit1=%h valid=%b state=%0d, required 8 0010 SETTLE",
                     digits1_o[7:4], dig_valid1_o, dut1.state_q);
        end
    endtask

    initial begin
        test_reset_mid_settle();
        test_glitch();
        test_full_frame();
        test_ghosting();
        test_repeat_digit();
        test_timeout();
        test_stable_one();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receiver end of the 4-digit multiplexed 7-segment drive, common-anode and active-low.
- Samples the anode strobes and cathode lines, qualifies each digit with a stability filter, and decodes segment patterns back to BCD.
- Publishes a per-digit register file, and a frame strobe once all four digits have been refreshed.
- Used for loop-back self-test of the display path and for monitoring display buses.

Parameters:
- STABLE_CNT, 4, consecutive identical samples (same anode, same pattern) required before a digit commits; legal range 1..255.
- TIMEOUT, 1000000, cycles without any commit before stale asserts; legal range 1..2^24-1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- an  in  4  anode enables, active-low; an[i]=0 selects digit i
- seg  in  7  cathodes, active-low, bit order gfedcba (seg[6]=g, seg[0]=a)
- digits  out  16  BCD digits; digit i at [4i+3:4i]
- dig_valid  out  4  digit i holds a legal committed value
- dig_blank  out  4  digit i last committed all-off (7'b1111111)
- dig_err  out  4  digit i last committed an illegal pattern
- frame_valid  out  1  one-cycle pulse when all four digits have committed since the last pulse
- stale  out  1  no commit for TIMEOUT cycles

Behaviour:
- Reset (async, rst=1):
  - digits=0, dig_valid=0, dig_blank=0, dig_err=0, frame_valid=0, stale=0.
  - FSM=IDLE; stable counter=0; timeout counter=0; committed mask=0.
- Inputs are registered once before use. All latencies below count from the registered sample.
- Selection is legal only if exactly one an bit is 0. If all an bits are 1, or more than one is 0, the sample is "no select".
- Pattern decode (active-low gfedcba):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0011000→9.
  - 1111111 → blank.
  - Anything else → illegal.
  - Transmitter codes 10–15 alias to 0–5, so they decode as 0–5 by design.
- FSM states:
  - IDLE: on a legal select, latch the anode index and pattern, set count=1, go to SETTLE. Otherwise stay in IDLE.
  - SETTLE: if the sample matches the latched anode and pattern, count+1. On a mismatch with a legal select, relatch and set count=1. On no select, go to IDLE. When count reaches STABLE_CNT, commit and go to HOLD.
  - HOLD: stay while the sample is unchanged. On no select, go to IDLE. On any change with a legal select, relatch and set count=1, go to SETTLE.
- Commit of digit i, visible the cycle after count reaches STABLE_CNT:
  - Legal pattern: digits[i] = value; dig_valid[i]=1, dig_blank[i]=0, dig_err[i]=0.
  - Blank: digits[i] unchanged; dig_valid[i]=0, dig_blank[i]=1, dig_err[i]=0.
  - Illegal: digits[i] unchanged; dig_valid[i]=0, dig_blank[i]=0, dig_err[i]=1.
  - Every commit sets committed mask bit i and clears the timeout counter and stale.
- STABLE_CNT=1: commit occurs on the first sample; SETTLE is transited for one cycle only.
- A digit held in HOLD does not recommit, so one dwell produces one commit.
- Frame strobe:
  - When a commit makes the committed mask equal 4'b1111, frame_valid pulses in the same cycle as that commit, and the mask clears to 0.
  - A commit of a digit whose mask bit is already set only updates that digit; it neither pulses nor clears the mask.
- Timeout: the counter increments every cycle without a commit and saturates at TIMEOUT. stale=1 when it equals TIMEOUT and is cleared by the next commit.
- A reset mid-dwell discards the partial count. The first commit after reset needs a full STABLE_CNT samples.

Decomposition:
- Package seg7_pkg:
  - Constants SEG_0..SEG_9 and SEG_BLANK (the 7-bit active-low patterns).
  - State enum {IDLE, SETTLE, HOLD}.
  - Function onehot0_low(an) returning {legal, index}.
- Sub-module seg7_pattern_decode: combinational, seg[6:0] → {legal, blank, value[3:0]}.
- The top module holds the input registers, FSM, counters and register file.

Test Plan (STABLE_CNT=4, TIMEOUT=64 for sim):
- Reset mid-SETTLE: an=1110, seg=0100100 for 2 cycles then rst pulse → all outputs 0. Re-applying for 4 cycles commits digits[3:0]=2 after a full 4 samples.
- Glitch rejection: an=1101, seg=0110000 for 3 cycles, then 0011001 for 4 cycles → exactly one commit, digits[7:4]=4, never 3.
- Full frame: scan digits 0..3 with patterns 9, 7, blank, illegal 0101010, each held 6 cycles →
  - digits = 16'h??79 (upper bytes unchanged);
  - dig_valid=0011, dig_blank=0100, dig_err=1000;
  - frame_valid pulses once on the digit-3 commit.
- Ghosting: an=1100 for 10 cycles with seg=0000000 → no commit, FSM stays in IDLE. Likewise an=1111.
- Repeat digit: commit digit 0 twice in one frame (separated by no select), then digits 1–3 → frame_valid pulses once, only after digit 3.
- Timeout: no select for 64 cycles → stale=1 at cycle 64. A legal 4-cycle dwell then clears stale on its commit.
